// File: rtl/encoding_serializer.sv
// Differential line encoder: serialises framed bytes LSB first and qualifies each bit.
// Define ENCODING_WHITEN_EN to add a PN9 whitener after the SHR_BITS preamble/SFD bits.
module encoding_serializer #(
  parameter int   SHR_BITS  = 80,
  parameter int   MAX_BITS  = 1200,
  parameter logic REF_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        indicator,
  output logic        bout,
  output logic        bvalid,
  output logic        eof,
  output logic        abort,
  output logic [10:0] bit_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [10:0] SHR_LIM = 11'(SHR_BITS);
  localparam logic [10:0] MAX_LIM = 11'(MAX_BITS);

  state_t      state;
  logic [10:0] cnt;
  logic        prev;
  logic        raw;
  logic        raw_w;
  logic        enc;

`ifdef ENCODING_WHITEN_EN
  logic [8:0]  lfsr;
  logic        whiten_zone;

  assign whiten_zone = (cnt >= SHR_LIM);
`else
  logic        unused_shr;

  assign unused_shr = ^SHR_LIM;
`endif

  // Preamble/SFD bits bypass the whitener so the receiver can still lock on them.
  always_comb begin
    raw   = din[cnt[2:0]];
    raw_w = raw;
`ifdef ENCODING_WHITEN_EN
    if (whiten_zone) raw_w = raw ^ lfsr[0];
`endif
    enc   = raw_w ^ prev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prev      <= REF_LEVEL;
      bout      <= REF_LEVEL;
      bvalid    <= 1'b0;
      eof       <= 1'b0;
      abort     <= 1'b0;
      bit_count <= '0;
`ifdef ENCODING_WHITEN_EN
      lfsr      <= 9'h1FF;
`endif
    end else begin
      bvalid <= 1'b0;
      eof    <= 1'b0;
      abort  <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          prev <= REF_LEVEL;
`ifdef ENCODING_WHITEN_EN
          lfsr <= 9'h1FF;
`endif
          if (indicator) state <= ACTIVE;
        end
        ACTIVE: begin
          // An over-length frame is dropped without emitting the offending bit.
          if (cnt == MAX_LIM) begin
            abort <= 1'b1;
            state <= IDLE;
          end else begin
            bout      <= enc;
            prev      <= enc;
            bvalid    <= 1'b1;
            bit_count <= cnt;
            cnt       <= cnt + 11'd1;
            eof       <= indicator;
            if (indicator) state <= IDLE;
`ifdef ENCODING_WHITEN_EN
            if (whiten_zone) lfsr <= {lfsr[0] ^ lfsr[5], lfsr[8:1]};
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoding_serializer.sv
// Bench for encoding_serializer: a long-limit and a 16-bit-limit instance checked
// against a cumulative-parity model every cycle, plus hand-computed frame expectations.
`timescale 1ns/1ps
module tb_encoding_serializer;

  localparam logic REF = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  din = '0;
  logic        indicator = 1'b0;
  logic        bout, bvalid, eof, abort;
  logic [10:0] bitCount;
  logic        boutS, bvalidS, eofS, abortS;
  logic [10:0] bitCountS;

  int compared = 0;
  int mismatched = 0;

  int logV[$], logB[$], logC[$], logE[$], modB[$];
  int sV[$], sA[$], sC[$];

  always #5 clk = ~clk;

  encoding_serializer dut (
    .clk(clk), .reset(reset), .din(din), .indicator(indicator),
    .bout(bout), .bvalid(bvalid), .eof(eof), .abort(abort), .bit_count(bitCount)
  );

  encoding_serializer #(.MAX_BITS(16)) dutShort (
    .clk(clk), .reset(reset), .din(din), .indicator(indicator),
    .bout(boutS), .bvalid(bvalidS), .eof(eofS), .abort(abortS), .bit_count(bitCountS)
  );

  // Whitening bit applied to frame bit k (zero when the whitener is absent).
  bit whitenBit[2048];
  initial begin : initWhiten
    logic [8:0] l;
    l = 9'h1FF;
    for (int k = 0; k < 2048; k++) begin
`ifdef ENCODING_WHITEN_EN
      if (k < 80) whitenBit[k] = 1'b0;
      else begin
        whitenBit[k] = l[0];
        l = {l[0] ^ l[5], l[8:1]};
      end
`else
      whitenBit[k] = 1'b0;
`endif
    end
  end

  // Model: the line level after bit k is REF xor the parity of all (whitened) bits 0..k.
  int  maxBits[2] = '{1200, 16};
  bit  mActive[2];
  int  mCnt[2];
  bit  mLevel[2];
  bit  eV[2], eB[2], eE[2], eA[2];
  int  eC[2];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mActive[i] <= 1'b0; mCnt[i] <= 0; mLevel[i] <= REF;
        eV[i] <= 1'b0; eB[i] <= REF; eE[i] <= 1'b0; eA[i] <= 1'b0; eC[i] <= 0;
      end else begin
        eV[i] <= 1'b0; eE[i] <= 1'b0; eA[i] <= 1'b0;
        if (!mActive[i]) begin
          if (indicator) begin
            mActive[i] <= 1'b1; mCnt[i] <= 0; mLevel[i] <= REF;
          end
        end else if (mCnt[i] >= maxBits[i]) begin
          eA[i] <= 1'b1; mActive[i] <= 1'b0;
        end else begin
          eV[i]     <= 1'b1;
          eC[i]     <= mCnt[i];
          eB[i]     <= mLevel[i] ^ din[mCnt[i] % 8] ^ whitenBit[mCnt[i]];
          mLevel[i] <= mLevel[i] ^ din[mCnt[i] % 8] ^ whitenBit[mCnt[i]];
          eE[i]     <= indicator;
          mCnt[i]   <= mCnt[i] + 1;
          if (indicator) mActive[i] <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every cycle outside reset: compare both instances against the model and log.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("bvalid", int'(bvalid), int'(eV[0]));
      checkOutput("eof", int'(eof), int'(eE[0]));
      checkOutput("abort", int'(abort), int'(eA[0]));
      if (eV[0]) begin
        checkOutput("bout", int'(bout), int'(eB[0]));
        checkOutput("bit_count", int'(bitCount), eC[0]);
      end
      checkOutput("short_bvalid", int'(bvalidS), int'(eV[1]));
      checkOutput("short_eof", int'(eofS), int'(eE[1]));
      checkOutput("short_abort", int'(abortS), int'(eA[1]));
      if (eV[1]) begin
        checkOutput("short_bout", int'(boutS), int'(eB[1]));
        checkOutput("short_bit_count", int'(bitCountS), eC[1]);
      end
      logV.push_back(int'(bvalid)); logB.push_back(int'(bout));
      logC.push_back(int'(bitCount)); logE.push_back(int'(eof));
      modB.push_back(int'(eB[0]));
      sV.push_back(int'(bvalidS)); sA.push_back(int'(abortS)); sC.push_back(int'(bitCountS));
    end
  end

  function automatic int pick(input int q[$], input int n);
    if (n >= 0 && n < q.size()) return q[n];
    return -1;
  endfunction

  function automatic int firstFrom(input int q[$], input int from);
    for (int n = from; n < q.size(); n++) if (q[n] == 1) return n;
    return -100;
  endfunction

  function automatic int total(input int q[$]);
    int s = 0;
    foreach (q[n]) s += q[n];
    return s;
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic ind);
    din = d;
    indicator = ind;
    @(negedge clk);
  endtask

  task automatic sendBytes(input logic [7:0] bytes[$], input bit withEnd);
    applyStimulus(8'h00, 1'b1);
    foreach (bytes[b])
      for (int j = 0; j < 8; j++)
        applyStimulus(bytes[b], withEnd && (b == bytes.size() - 1) && (j == 7));
  endtask

  task automatic resetDut();
    reset = 1'b1; din = '0; indicator = 1'b0;
    repeat (2) @(negedge clk);
    logV.delete(); logB.delete(); logC.delete(); logE.delete(); modB.delete();
    sV.delete(); sA.delete(); sC.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkAaFrame(input string tag);
    int idx;
    int expAa[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    idx = firstFrom(logV, 0);
    checkOutput({tag, "_latency"}, idx, 2);
    for (int k = 0; k < 8; k++) begin
      checkOutput({tag, "_bout"}, pick(logB, idx + k), expAa[k]);
      checkOutput({tag, "_model"}, pick(modB, idx + k), expAa[k]);
      checkOutput({tag, "_count"}, pick(logC, idx + k), k);
      checkOutput({tag, "_valid"}, pick(logV, idx + k), 1);
    end
    checkOutput({tag, "_eofLast"}, pick(logE, idx + 7), 1);
    checkOutput({tag, "_eofTotal"}, total(logE), 1);
    checkOutput({tag, "_validAfter"}, pick(logV, idx + 8), 0);
  endtask

  initial begin
    int idx;
    int exp0f[8] = '{1, 0, 1, 0, 0, 0, 0, 0};

    $display("[TB] reset state");
    resetDut();
    checkOutput("rst_bout", int'(bout), int'(REF));
    checkOutput("rst_bvalid", int'(bvalid), 0);
    checkOutput("rst_count", int'(bitCount), 0);

    $display("[TB] single 0xAA frame");
    sendBytes('{8'hAA}, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    checkAaFrame("aa");

    $display("[TB] preamble/SFD plus two zero bytes");
    resetDut();
    sendBytes('{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                8'hF3, 8'h98, 8'h00, 8'h00}, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    idx = firstFrom(logV, 0);
    checkOutput("shr_validTotal", total(logV), 96);
    checkOutput("shr_lastCount", pick(logC, idx + 95), 95);
    checkOutput("shr_eofLast", pick(logE, idx + 95), 1);
    checkOutput("shr_eofTotal", total(logE), 1);
    checkOutput("shr_bit79", pick(logB, idx + 79), 1);
`ifdef ENCODING_WHITEN_EN
    for (int k = 0; k < 8; k++) checkOutput("shr_whitenToggle", pick(logB, idx + 80 + k), k % 2);
`else
    for (int k = 80; k < 96; k++) checkOutput("shr_zeroHold", pick(logB, idx + k), 1);
`endif

    $display("[TB] over-length frame on the 16-bit instance");
    resetDut();
    applyStimulus(8'h00, 1'b1);
    repeat (20) applyStimulus(8'h5A, 1'b0);
    repeat (3) applyStimulus(8'h00, 1'b0);
    sendBytes('{8'hAA}, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    idx = firstFrom(sV, 0);
    for (int k = 0; k < 16; k++) checkOutput("abt_valid", pick(sV, idx + k), 1);
    checkOutput("abt_count15", pick(sC, idx + 15), 15);
    checkOutput("abt_pulse", pick(sA, idx + 16), 1);
    checkOutput("abt_noValidAt", pick(sV, idx + 16), 0);
    checkOutput("abt_noValidAfter", pick(sV, idx + 17), 0);
    checkOutput("abt_pulseTotal", total(sA), 1);
    checkOutput("abt_validTotal", total(sV), 24);
    checkOutput("abt_restartCount", pick(sC, firstFrom(sV, idx + 17)), 0);

    $display("[TB] reset in the middle of a frame");
    resetDut();
    applyStimulus(8'h00, 1'b1);
    repeat (6) applyStimulus(8'hAA, 1'b0);
    checkOutput("mid_preValid", int'(bvalid), 1);
    checkOutput("mid_preCount", int'(bitCount), 5);
    checkOutput("mid_preBout", int'(bout), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_bvalid", int'(bvalid), 0);
    checkOutput("mid_bout", int'(bout), int'(REF));
    checkOutput("mid_count", int'(bitCount), 0);
    checkOutput("mid_eof", int'(eof), 0);
    resetDut();
    sendBytes('{8'hAA}, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    checkAaFrame("postRst");

    $display("[TB] back-to-back frames");
    resetDut();
    sendBytes('{8'hAA}, 1'b1);
    sendBytes('{8'h0F}, 1'b1);
    repeat (3) applyStimulus(8'h00, 1'b0);
    idx = firstFrom(logV, 0);
    for (int k = 0; k < 8; k++) checkOutput("b2b_countA", pick(logC, idx + k), k);
    checkOutput("b2b_gap", pick(logV, idx + 8), 0);
    for (int k = 0; k < 8; k++) begin
      checkOutput("b2b_validB", pick(logV, idx + 9 + k), 1);
      checkOutput("b2b_countB", pick(logC, idx + 9 + k), k);
      checkOutput("b2b_boutB", pick(logB, idx + 9 + k), exp0f[k]);
    end
    checkOutput("b2b_eofTotal", total(logE), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
